// File: rtl/sw_scanner_if.sv
// sw_scanner_if: switch-bank inputs, debounced level word and change-event
// stream. The scanner drives through the master modport; a consumer
// connects through the slave modport.
interface sw_scanner_if #(
    parameter int unsigned NUM_SW = 16
);
    localparam int unsigned IW = $clog2(NUM_SW);

    logic [NUM_SW-1:0] sw;
    logic [NUM_SW-1:0] sw_stable;
    logic              evt_valid;
    logic              evt_ready;
    logic [IW-1:0]     evt_index;
    logic              evt_level;

    modport master (
        input  sw,
        input  evt_ready,
        output sw_stable,
        output evt_valid,
        output evt_index,
        output evt_level
    );

    modport slave (
        output sw,
        output evt_ready,
        input  sw_stable,
        input  evt_valid,
        input  evt_index,
        input  evt_level
    );
endinterface

// File: rtl/sw_scanner.sv
// sw_scanner: synchronizes and debounces a slide-switch bank, publishes the
// stable level word and queues one {index, level} event per debounced change.
module sw_scanner #(
    parameter int unsigned NUM_SW      = 16,
    parameter int unsigned TICK_CYCLES = 1000000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input logic            clk,
    input logic            rst,
    sw_scanner_if.master   bus
);
    localparam int unsigned IW = $clog2(NUM_SW);
    localparam int unsigned EW = IW + 1;
    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [NUM_SW-1:0] sync1_q;
    logic [NUM_SW-1:0] sync2_q;
    logic [PW-1:0]     presc_q;
    logic              tick;
    logic [NUM_SW-1:0] samp_prev_q;
    logic [NUM_SW-1:0] stable_q;
    logic [NUM_SW-1:0] stable_d;
    logic [NUM_SW-1:0] pending_q;
    logic [NUM_SW-1:0] pending_d;
    logic [NUM_SW-1:0] accept;
    logic [NUM_SW-1:0] clr_mask;
    logic [IW-1:0]     push_idx;
    logic              push_lvl;
    logic              found;
    logic              push;
    logic              pop;
    logic              full;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [CW-1:0]     cnt_q;

    // Two-flop synchronizer on every raw switch bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.sw;
            sync2_q <= sync1_q;
        end
    end

    assign tick = (presc_q == PW'(TICK_CYCLES - 1));

    // Free-running debounce sample prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Lowest pending switch is the next event candidate
    always_comb begin
        found    = 1'b0;
        push_idx = '0;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            if (pending_q[i] && !found) begin
                found    = 1'b1;
                push_idx = IW'(i);
            end
        end
    end

    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign push     = (pending_q != '0) && !full;
    assign pop      = (cnt_q != '0) && bus.evt_ready;
    assign push_lvl = stable_q[push_idx];

    // Accept a level seen on two consecutive ticks that differs from the stable one;
    // applying the set after the clear makes a same-cycle set win.
    always_comb begin
        clr_mask = '0;
        if (push) begin
            clr_mask[push_idx] = 1'b1;
        end
        accept    = {NUM_SW{tick}} & ~(sync2_q ^ samp_prev_q) & (sync2_q ^ stable_q);
        stable_d  = stable_q ^ accept;
        pending_d = (pending_q & ~clr_mask) | accept;
    end

    // Debounce state: previous tick sample, stable word, pending change flags
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_prev_q <= '0;
            stable_q    <= '0;
            pending_q   <= '0;
        end else begin
            if (tick) begin
                samp_prev_q <= sync2_q;
            end
            stable_q  <= stable_d;
            pending_q <= pending_d;
        end
    end

    // Event FIFO; push is gated on the pre-pop count, so a same-cycle pop never unblocks it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {push_idx, push_lvl};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.sw_stable = stable_q;
    assign bus.evt_valid = (cnt_q != '0);
    assign {bus.evt_index, bus.evt_level} = mem_q[rd_q];

endmodule

// File: tb/tb_sw_scanner.sv
// tb_sw_scanner: directed stimulus for sw_scanner with a queue-based
// reference model checked against the DUT every cycle.
module tb_sw_scanner;
    localparam int unsigned NUM_SW = 16;
    localparam int unsigned TICK   = 4;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sw_scanner_if #(.NUM_SW(NUM_SW)) bus ();

    sw_scanner #(
        .NUM_SW      (NUM_SW),
        .TICK_CYCLES (TICK),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: history of raw inputs, tick from cycle count, SV queues for events
    bit           m_init = 1'b0;
    int unsigned  m_cyc;
    logic [15:0]  m_h1, m_h2, m_prev, m_stable, m_pend, m_sync;
    logic [4:0]   m_q[$];
    logic [4:0]   m_log[$];
    bit           m_full;
    int           m_lo;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1'b1;
            m_cyc = 0;
            m_h1 = '0; m_h2 = '0; m_prev = '0; m_stable = '0; m_pend = '0;
            m_q.delete();
        end else begin
            m_sync = m_h2;
            m_full = (m_q.size() == DEPTH);
            if (m_q.size() != 0 && bus.evt_ready) begin
                m_log.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (m_pend != 0 && !m_full) begin
                m_lo = -1;
                for (int i = 15; i >= 0; i--) if (m_pend[i]) m_lo = i;
                m_q.push_back({m_lo[3:0], m_stable[m_lo]});
                m_pend[m_lo] = 1'b0;
            end
            if (m_cyc % TICK == TICK - 1) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_sync[i] == m_prev[i] && m_sync[i] != m_stable[i]) begin
                        m_stable[i] = m_sync[i];
                        m_pend[i]   = 1'b1;
                    end
                end
                m_prev = m_sync;
            end
            m_h2 = m_h1;
            m_h1 = bus.sw;
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_init) begin
            chk("sw_stable", 32'(bus.sw_stable), 32'(m_stable));
            chk("evt_valid", 32'(bus.evt_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0)
                chk("evt_head", 32'({bus.evt_index, bus.evt_level}), 32'(m_q[0]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sw = '0;
        bus.evt_ready = 1'b0;
        step(3);
        rst = 1'b0;
        m_log.delete();
    endtask

    logic [4:0] exp6 [6];
    bit         settled;

    initial begin
        bus.sw = '0;
        bus.evt_ready = 1'b0;

        // Quiet reset
        do_reset();
        step(200);
        chk("quiet_stable", 32'(bus.sw_stable), 32'h0);
        chk("quiet_valid", 32'(bus.evt_valid), 32'h0);
        chk("quiet_log", 32'(m_log.size()), 32'd0);

        // Single edge on switch 3
        do_reset();
        bus.evt_ready = 1'b1;
        bus.sw = 16'h0008;
        settled = 1'b0;
        for (int k = 0; k < 11 && !settled; k++) begin
            step(1);
            if (bus.sw_stable == 16'h0008) settled = 1'b1;
        end
        chk("single_settle", 32'(settled), 32'd1);
        step(10);
        chk("single_count", 32'(m_log.size()), 32'd1);
        if (m_log.size() > 0) chk("single_evt", 32'(m_log[0]), 32'h07);
        chk("single_idle", 32'(bus.evt_valid), 32'h0);

        // Glitch rejection on switch 5 at four tick offsets
        m_log.delete();
        for (int off = 0; off < 4; off++) begin
            step(off + 1);
            bus.sw = 16'h0028;
            step(3);
            bus.sw = 16'h0008;
            step(12);
        end
        chk("glitch_stable", 32'(bus.sw_stable), 32'h0008);
        chk("glitch_log", 32'(m_log.size()), 32'd0);

        // Simultaneous edges with backpressure
        do_reset();
        bus.sw = 16'h8421;
        step(30);
        chk("simul_stable", 32'(bus.sw_stable), 32'h8421);
        chk("simul_qdepth", 32'(m_q.size()), 32'd4);
        chk("simul_valid", 32'(bus.evt_valid), 32'h1);
        bus.evt_ready = 1'b1;
        step(4);
        chk("simul_drained", 32'(m_log.size()), 32'd4);
        chk("simul_empty", 32'(bus.evt_valid), 32'h0);
        if (m_log.size() == 4) begin
            chk("simul_e0", 32'(m_log[0]), 32'h01);
            chk("simul_e1", 32'(m_log[1]), 32'h0B);
            chk("simul_e2", 32'(m_log[2]), 32'h15);
            chk("simul_e3", 32'(m_log[3]), 32'h1F);
        end

        // Full queue, overflow held as pending
        do_reset();
        bus.sw = 16'h1256;
        step(30);
        chk("full_qdepth", 32'(m_q.size()), 32'd4);
        chk("full_pending", 32'(m_pend), 32'h1200);
        chk("full_valid", 32'(bus.evt_valid), 32'h1);
        bus.evt_ready = 1'b1;
        step(12);
        exp6 = '{5'h03, 5'h05, 5'h09, 5'h0D, 5'h13, 5'h19};
        chk("full_count", 32'(m_log.size()), 32'd6);
        if (m_log.size() == 6)
            for (int i = 0; i < 6; i++) chk($sformatf("full_e%0d", i), 32'(m_log[i]), 32'(exp6[i]));

        // Coalescing: switch 2 rises and falls while the queue is full
        do_reset();
        bus.sw = 16'h8421;
        step(30);
        bus.sw = 16'h8425;
        step(30);
        chk("coal_rise_stable", 32'(bus.sw_stable), 32'h8425);
        chk("coal_rise_pend", 32'(m_pend), 32'h0004);
        bus.sw = 16'h8421;
        step(30);
        chk("coal_fall_stable", 32'(bus.sw_stable), 32'h8421);
        chk("coal_fall_pend", 32'(m_pend), 32'h0004);
        bus.evt_ready = 1'b1;
        step(12);
        chk("coal_count", 32'(m_log.size()), 32'd5);
        if (m_log.size() == 5) chk("coal_evt", 32'(m_log[4]), 32'h04);

        // Reset with events queued
        do_reset();
        bus.sw = 16'h0421;
        step(30);
        chk("rstq_qdepth", 32'(m_q.size()), 32'd3);
        chk("rstq_valid", 32'(bus.evt_valid), 32'h1);
        rst = 1'b1;
        bus.sw = '0;
        step(1);
        chk("rstq_valid_clr", 32'(bus.evt_valid), 32'h0);
        chk("rstq_stable_clr", 32'(bus.sw_stable), 32'h0);
        step(2);
        rst = 1'b0;
        m_log.delete();
        bus.evt_ready = 1'b1;
        step(40);
        chk("rstq_no_stale", 32'(m_log.size()), 32'd0);
        chk("rstq_idle", 32'(bus.evt_valid), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sw_scanner.md
# sw_scanner

Input-side counterpart to the LED drivers: samples the board's slide-switch bank, synchronizes and debounces every switch, and publishes both a stable switch word and a queue of per-switch change events. Downstream logic reads `sw_stable` for the current level, or consumes `{evt_index, evt_level}` over a valid/ready handshake to react to edges without polling.

## Interface
- `NUM_SW`, 16: number of switches; the event index width is `$clog2(NUM_SW)`.
- `TICK_CYCLES`, 1000000: debounce sample period in `clk` cycles (10 ms at 100 MHz); ≥ 2.
- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥ 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  NUM_SW  raw switch levels, asynchronous to `clk`.
- `sw_stable`  out  NUM_SW  debounced switch levels, registered.
- `evt_valid`  out  1  event queue non-empty.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_index`  out  clog2(NUM_SW)  switch number of the head event.
- `evt_level`  out  1  new debounced level of that switch.

## Operation
- Synchronizer: 2-flop synchronizer per bit; `sw_sync` is `sw` delayed by 2 cycles.
- Prescaler: counts 0..TICK_CYCLES-1 and wraps. `tick` is asserted in the cycle where count == TICK_CYCLES-1.
- Debounce: on `tick`, for each bit i:
  - `samp_prev[i] <= sw_sync[i]`;
  - if `sw_sync[i] == samp_prev[i]` and `!= sw_stable[i]`, then `sw_stable[i] <= sw_sync[i]` and `pending[i] <= 1`.
  - A level therefore has to agree across two consecutive ticks.
  - A glitch shorter than TICK_CYCLES is never accepted.
- Event encoder:
  - Each cycle, if `pending != 0` and the FIFO is not full, push `{i, sw_stable[i]}` for the lowest set i and clear `pending[i]`.
  - Only one push per cycle.
  - The level is sampled at push time. A switch that toggles and returns to its old level while still pending produces one event carrying the current level. Events are coalesced, never dropped.
  - If a set and a clear of `pending[i]` happen in the same cycle, the set wins.
- FIFO:
  - Push and pop are allowed in the same cycle.
  - A push is blocked only when count == FIFO_DEPTH. A pop in the same cycle does not unblock it.
  - Pop occurs on `evt_valid && evt_ready`.
  - `evt_index`/`evt_level` show the head entry; they are don't-care when `evt_valid` = 0.
- Reset values: `sw_sync`, `samp_prev`, `sw_stable`, `pending` = 0; prescaler = 0; FIFO empty; `evt_valid` = 0, `evt_index` = 0, `evt_level` = 0. Switches already high at reset release are reported as normal 0→1 events once they are debounced.
- Reset mid-operation discards queued and pending events. On the cycle after `rst` is sampled high, `evt_valid` = 0 and `sw_stable` = 0.

## Timing
- `sw` to `sw_sync`: 2 cycles.
- For an accepting tick at cycle T:
  - `sw_stable` and `pending` update at T+1.
  - The first push is evaluated at T+1.
  - `evt_valid` = 1 at T+2.
  - Further events from the same tick follow at one per cycle, in ascending index order.
- Worst case, `sw` edge to `sw_stable`: 2 + 2·TICK_CYCLES + 1 cycles.
- Handshake: the consumer may hold `evt_ready` high continuously, giving a throughput of 1 event per cycle. `evt_valid` never deasserts without a pop or a reset.
- Max events in flight: FIFO_DEPTH queued + NUM_SW pending.

## Test plan
Bench parameters: TICK_CYCLES=4, FIFO_DEPTH=4, NUM_SW=16.
- Quiet reset: `rst` for 3 cycles with `sw`=0x0000, then hold for 200 cycles → `sw_stable`=0x0000 and `evt_valid`=0 throughout.
- Single edge: `sw`=0x0008 held, `evt_ready`=1 → `sw_stable`=0x0008 within 11 cycles. Exactly one event, (3,1), then `evt_valid`=0.
- Glitch rejection: `sw[5]`=1 for 3 cycles, then 0, repeated at offsets 0..3 relative to the tick → no event, `sw_stable[5]`=0.
- Simultaneous edges plus backpressure: `sw` 0x0000→0x8421 with `evt_ready`=0 → `sw_stable`=0x8421 and the FIFO fills with (0,1),(5,1),(10,1),(15,1). With `evt_ready`=1 they drain in that order on 4 consecutive cycles.
- Full queue, no loss: 6 bits {1,2,4,6,9,12} rise with `evt_ready`=0 → 4 events queued and `pending`=bits 9,12. After draining, 6 events arrive in ascending order with level 1.
- Coalescing and reset:
  - `sw[2]` rises while the FIFO is full and falls before the drain (both debounced) → one event (2,0).
  - Asserting `rst` with 3 events queued → `evt_valid`=0 on the next cycle, and no stale events after release.
